// File: rtl/idex_hazard_ctrl.sv
// ID/EX consumer-side hazard controller: load-use stalls, taken-branch flushes,
// multi-cycle multiply freeze of EX, and a saturating stall-cycle counter.
module idex_hazard_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        IFID_Rn,
  input  logic [4:0]        IFID_Rm,
  input  logic              ID_usesRn,
  input  logic              ID_usesRm,
  input  logic [4:0]        EX_Rd,
  input  logic              EX_read_enable,
  input  logic              EX_NOOP,
  input  logic              EX_BrTaken,
  input  logic [1:0]        EX_ALUResult,
  output logic              PC_en,
  output logic              IFID_en,
  output logic              IFID_flush,
  output logic              IDEX_en,
  output logic              IDEX_bubble,
  output logic              EXMEM_bubble,
  output logic [PERF_W-1:0] stall_count
);

  localparam int unsigned CNT_W    = $clog2(MUL_LATENCY) + 1;
  localparam int unsigned CNT_INIT = (MUL_LATENCY >= 3) ? MUL_LATENCY - 3 : 0;
  localparam bit          MUL_STALLS = (MUL_LATENCY >= 2);
  localparam bit          MUL_SHORT  = (MUL_LATENCY == 2);

  typedef enum logic [1:0] {RUN, MUL_BUSY, MUL_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_q;
  logic               mul_ex, lu, br_ex;

  // Hazard detection on the EX-side view of ID/EX
  always_comb begin
    mul_ex = (EX_ALUResult == 2'b10) && !EX_NOOP;
    br_ex  = EX_BrTaken && !EX_NOOP;
    lu     = EX_read_enable && !EX_NOOP && (EX_Rd != 5'd31) &&
             ((ID_usesRn && (IFID_Rn == EX_Rd)) || (ID_usesRm && (IFID_Rm == EX_Rd)));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_en        = 1'b1;
    IFID_en      = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_en      = 1'b1;
    IDEX_bubble  = 1'b0;
    EXMEM_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (br_ex) begin
          IFID_flush  = 1'b1;
          IDEX_bubble = 1'b1;
        end else if (mul_ex && MUL_STALLS) begin
          PC_en        = 1'b0;
          IFID_en      = 1'b0;
          IDEX_en      = 1'b0;
          EXMEM_bubble = 1'b1;
          if (MUL_SHORT) begin
            state_d = MUL_DONE;
          end else begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_W'(CNT_INIT);
          end
        end else if (lu) begin
          PC_en       = 1'b0;
          IFID_en     = 1'b0;
          IDEX_bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        PC_en        = 1'b0;
        IFID_en      = 1'b0;
        IDEX_en      = 1'b0;
        EXMEM_bubble = 1'b1;
        if (cnt_q == '0) state_d = MUL_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      MUL_DONE: state_d = RUN;
      default:  state_d = RUN;
    endcase
    // Reset squashes the whole front end regardless of state
    if (reset) begin
      PC_en        = 1'b0;
      IFID_en      = 1'b0;
      IFID_flush   = 1'b1;
      IDEX_en      = 1'b1;
      IDEX_bubble  = 1'b1;
      EXMEM_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!PC_en && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Self-checking bench for idex_hazard_ctrl: directed scenarios then random traffic
// compared against a cycle-index reference model of the hazard rules.
module tb_idex_hazard_ctrl;

  localparam int unsigned L = 4;

  logic       clk, reset;
  logic [4:0] IFID_Rn, IFID_Rm, EX_Rd;
  logic       ID_usesRn, ID_usesRm, EX_read_enable, EX_NOOP, EX_BrTaken;
  logic [1:0] EX_ALUResult;
  logic       PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_bubble;
  logic [31:0] stall_count;
  logic       s_PC_en, s_IFID_en, s_IFID_flush, s_IDEX_en, s_IDEX_bubble, s_EXMEM_bubble;
  logic [3:0] stall_count4;

  int total = 0;
  int bad   = 0;

  // Reference model state: cycle index within an in-flight multiply (0 = none)
  int     mul_cyc = 0;
  longint cnt_m   = 0;

  idex_hazard_ctrl #(.MUL_LATENCY(L), .PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm), .ID_usesRn(ID_usesRn), .ID_usesRm(ID_usesRm),
    .EX_Rd(EX_Rd), .EX_read_enable(EX_read_enable), .EX_NOOP(EX_NOOP),
    .EX_BrTaken(EX_BrTaken), .EX_ALUResult(EX_ALUResult),
    .PC_en(PC_en), .IFID_en(IFID_en), .IFID_flush(IFID_flush), .IDEX_en(IDEX_en),
    .IDEX_bubble(IDEX_bubble), .EXMEM_bubble(EXMEM_bubble), .stall_count(stall_count)
  );

  idex_hazard_ctrl #(.MUL_LATENCY(L), .PERF_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm), .ID_usesRn(ID_usesRn), .ID_usesRm(ID_usesRm),
    .EX_Rd(EX_Rd), .EX_read_enable(EX_read_enable), .EX_NOOP(EX_NOOP),
    .EX_BrTaken(EX_BrTaken), .EX_ALUResult(EX_ALUResult),
    .PC_en(s_PC_en), .IFID_en(s_IFID_en), .IFID_flush(s_IFID_flush), .IDEX_en(s_IDEX_en),
    .IDEX_bubble(s_IDEX_bubble), .EXMEM_bubble(s_EXMEM_bubble), .stall_count(stall_count4)
  );

  always #5 clk = ~clk;

  // {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_bubble}
  localparam logic [5:0] O_RST   = 6'b001111;
  localparam logic [5:0] O_DEF   = 6'b110100;
  localparam logic [5:0] O_LU    = 6'b000110;
  localparam logic [5:0] O_MUL   = 6'b000001;
  localparam logic [5:0] O_FLUSH = 6'b111110;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] model_out();
    bit mul, br, lu;
    mul = (EX_ALUResult == 2'd2) && !EX_NOOP;
    br  = EX_BrTaken && !EX_NOOP;
    lu  = EX_read_enable && !EX_NOOP && (EX_Rd != 5'd31) &&
          ((ID_usesRn && IFID_Rn == EX_Rd) || (ID_usesRm && IFID_Rm == EX_Rd));
    if (reset)                             return O_RST;
    if (mul_cyc >= 2 && mul_cyc < int'(L)) return O_MUL;
    if (mul_cyc != 0)                      return O_DEF;
    if (br)                                return O_FLUSH;
    if (mul && L >= 2)                     return O_MUL;
    if (lu)                                return O_LU;
    return O_DEF;
  endfunction

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  // Called just after inputs change at a falling edge; checks, then advances one cycle
  task automatic tick(input bit use_dir, input logic [5:0] exp_dir, input string tag);
    logic [5:0] m, obs, obs_s;
    bit started;
    #1;
    if (reset) begin
      mul_cyc = 0;
      cnt_m   = 0;
    end
    m     = model_out();
    obs   = {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_bubble};
    obs_s = {s_PC_en, s_IFID_en, s_IFID_flush, s_IDEX_en, s_IDEX_bubble, s_EXMEM_bubble};
    check({tag, "_out"},  64'(obs), 64'(use_dir ? exp_dir : m));
    check({tag, "_outs"}, 64'(obs_s), 64'(m));
    check({tag, "_cnt"},  64'(stall_count), 64'(cnt_m));
    check({tag, "_cnt4"}, 64'(stall_count4), 64'(sat15(cnt_m)));
    if (!reset) begin
      started = (mul_cyc == 0) && (m == O_MUL);
      if (!m[5]) cnt_m++;
      if (started)           mul_cyc = 2;
      else if (mul_cyc != 0) mul_cyc = (mul_cyc == int'(L)) ? 0 : mul_cyc + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    IFID_Rn = 5'd0; IFID_Rm = 5'd0; ID_usesRn = 1'b0; ID_usesRm = 1'b0;
    EX_Rd = 5'd0; EX_read_enable = 1'b0; EX_NOOP = 1'b0; EX_BrTaken = 1'b0;
    EX_ALUResult = 2'b00;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic uses_rn);
    idle();
    EX_read_enable = 1'b1; EX_Rd = rd; IFID_Rn = rd; ID_usesRn = uses_rn;
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'(($urandom_range(0, 3)));
  endfunction

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    idle();
    @(negedge clk);

    tick(1, O_RST, "rst0");
    tick(1, O_RST, "rst1");
    reset = 1'b0;
    tick(1, O_DEF, "rel0");
    tick(1, O_DEF, "rel1");

    load_use(5'd3, 1'b1);
    tick(1, O_LU, "lu");
    idle();
    tick(1, O_DEF, "lu_after");
    check("lu_cnt1", 64'(stall_count), 64'd1);

    load_use(5'd31, 1'b1);
    tick(1, O_DEF, "lu_r31");
    load_use(5'd3, 1'b0);
    tick(1, O_DEF, "lu_nouse");
    EX_NOOP = 1'b1; ID_usesRn = 1'b1;
    tick(1, O_DEF, "lu_noop");

    idle();
    EX_ALUResult = 2'b10;
    tick(1, O_MUL, "mul1");
    tick(1, O_MUL, "mul2");
    tick(1, O_MUL, "mul3");
    tick(1, O_DEF, "mul4");
    idle();
    tick(1, O_DEF, "mul_after");
    check("mul_cnt4", 64'(stall_count), 64'd4);

    load_use(5'd5, 1'b1);
    EX_BrTaken = 1'b1;
    tick(1, O_FLUSH, "br_lu");
    EX_NOOP = 1'b1;
    tick(1, O_DEF, "br_noop");
    idle();
    EX_BrTaken = 1'b1; EX_ALUResult = 2'b10;
    tick(1, O_FLUSH, "br_mul");

    idle();
    EX_ALUResult = 2'b10;
    tick(1, O_MUL, "mrst1");
    tick(1, O_MUL, "mrst2");
    reset = 1'b1;
    tick(1, O_RST, "mrst_rst");
    reset = 1'b0;
    idle();
    tick(1, O_DEF, "mrst_rel");
    check("mrst_cnt0", 64'(stall_count), 64'd0);

    load_use(5'd7, 1'b1);
    for (int i = 0; i < 20; i++) tick(1, O_LU, "sat");
    idle();
    tick(1, O_DEF, "sat_end");
    check("sat_cnt20", 64'(stall_count), 64'd20);
    check("sat_cnt15", 64'(stall_count4), 64'd15);

    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 59) == 0);
      IFID_Rn        = rreg();
      IFID_Rm        = rreg();
      EX_Rd          = rreg();
      ID_usesRn      = 1'($urandom_range(0, 1));
      ID_usesRm      = 1'($urandom_range(0, 1));
      EX_read_enable = 1'($urandom_range(0, 1));
      EX_NOOP        = ($urandom_range(0, 4) == 0);
      EX_BrTaken     = ($urandom_range(0, 5) == 0);
      EX_ALUResult   = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      tick(0, 6'b0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
